// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  // Operation select
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  // Divide-class operations share the restoring-division datapath.
  function automatic logic op_is_div(input md_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Operand magnitude extraction, special-case detection and final sign
// correction around the unsigned shift-add / restoring-divide core.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  md_op_e                    op,
  input  logic [DATA_WIDTH-1:0]     src_a,
  input  logic [DATA_WIDTH-1:0]     src_b,
  output logic [DATA_WIDTH-1:0]     a_mag,
  output logic [DATA_WIDTH-1:0]     b_mag,
  output logic                      res_neg,
  output logic                      special,
  output logic [DATA_WIDTH-1:0]     special_res,
  input  md_op_e                    fix_op,
  input  logic                      fix_neg,
  input  logic [2*DATA_WIDTH-1:0]   raw,
  output logic [DATA_WIDTH-1:0]     result
);

  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  logic a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [2*W-1:0] prod;

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] v);
    return ~v + W'(1);
  endfunction

  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v);
    return ~v + (2*W)'(1);
  endfunction

  // Operand side: magnitudes, result sign and the short-circuit cases
  always_comb begin
    a_signed    = op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    b_signed    = op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
    a_neg       = a_signed && src_a[W-1];
    b_neg       = b_signed && src_b[W-1];
    a_mag       = a_neg ? neg_w(src_a) : src_a;
    b_mag       = b_neg ? neg_w(src_b) : src_b;
    // Remainder follows the dividend; everything else is the sign product
    res_neg     = (op == MD_REM) ? a_neg : (a_neg ^ b_neg);
    div_zero    = op_is_div(op) && (src_b == '0);
    div_ovf     = (op inside {MD_DIV, MD_REM}) && (src_a == MOST_NEG) && (src_b == '1);
    special     = div_zero || div_ovf;
    special_res = '0;
    if (div_zero)
      special_res = (op inside {MD_DIV, MD_DIVU}) ? '1 : src_a;
    else if (div_ovf)
      special_res = (op == MD_DIV) ? src_a : '0;
  end

  // Result side: apply sign and pick the half that the operation returns
  always_comb begin
    prod   = fix_neg ? neg_2w(raw) : raw;
    result = '0;
    case (fix_op)
      MD_MUL:                         result = prod[W-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:   result = prod[2*W-1:W];
      MD_DIV, MD_DIVU:                result = fix_neg ? neg_w(raw[W-1:0]) : raw[W-1:0];
      MD_REM, MD_REMU:                result = fix_neg ? neg_w(raw[2*W-1:W]) : raw[2*W-1:W];
      default:                        result = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide unit. One 2*W shift register
// is shared by both algorithms; one iteration per cycle while BUSY.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Start,
  input  logic                  Flush,
  input  logic [OP_WIDTH-1:0]   MDControl,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Zero
);

  localparam int W = DATA_WIDTH;

  md_state_e            state, state_next;
  md_op_e               op_in, op_r;
  logic [CNT_WIDTH-1:0] cnt;
  logic [2*W-1:0]       acc, acc_step;
  logic [W-1:0]         opnd_b, a_mag, b_mag, special_res, fixed_res;
  logic [W:0]           mul_sum, rem_sh, div_diff;
  logic                 neg_r, res_neg, special, accept, last_iter;

  assign op_in     = md_op_e'(MDControl[2:0]);
  assign accept    = Start && !Flush && ((state == IDLE) || (state == DONE));
  assign last_iter = (state == BUSY) && (cnt == CNT_WIDTH'(1));
  assign Busy      = (state == BUSY);
  assign Done      = (state == DONE);
  assign Zero      = (Result == '0);

  muldiv_sign_fix #(.DATA_WIDTH(DATA_WIDTH)) u_sign_fix (
    .op          (op_in),
    .src_a       (SrcA),
    .src_b       (SrcB),
    .a_mag       (a_mag),
    .b_mag       (b_mag),
    .res_neg     (res_neg),
    .special     (special),
    .special_res (special_res),
    .fix_op      (op_r),
    .fix_neg     (neg_r),
    .raw         (acc_step),
    .result      (fixed_res)
  );

  // One iteration of either shift-add multiply or restoring divide
  always_comb begin
    acc_step = acc;
    mul_sum  = '0;
    rem_sh   = '0;
    div_diff = '0;
    if (op_is_div(op_r)) begin
      // Upper half is the partial remainder, lower half collects quotient bits
      rem_sh   = {acc[2*W-1:W], acc[W-1]};
      div_diff = rem_sh - {1'b0, opnd_b};
      if (!div_diff[W])
        acc_step = {div_diff[W-1:0], acc[W-2:0], 1'b1};
      else
        acc_step = {rem_sh[W-1:0], acc[W-2:0], 1'b0};
    end else begin
      // Add multiplicand into the upper half when the current LSB is set
      mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opnd_b : {W{1'b0}})};
      acc_step = {mul_sum, acc[W-1:1]};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; Flush wins over everything but reset
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = special ? DONE : BUSY;
      BUSY:    if (last_iter) state_next = DONE;
      DONE:    state_next = accept ? (special ? DONE : BUSY) : IDLE;
      default: state_next = IDLE;
    endcase
    if (Flush) state_next = IDLE;
  end

  // Operand latch, iteration register, counter and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      opnd_b <= '0;
      op_r   <= MD_MUL;
      neg_r  <= 1'b0;
      Result <= '0;
    end else if (Flush) begin
      cnt <= '0;
    end else if (accept) begin
      op_r   <= op_in;
      neg_r  <= res_neg;
      opnd_b <= b_mag;
      acc    <= {{W{1'b0}}, a_mag};
      if (special) begin
        cnt    <= '0;
        Result <= special_res;
      end else begin
        cnt <= CNT_WIDTH'(DATA_WIDTH);
      end
    end else if (state == BUSY) begin
      acc <= acc_step;
      cnt <= cnt - CNT_WIDTH'(1);
      // The final iteration's value goes straight to Result on DONE entry
      if (last_iter) Result <= fixed_res;
    end
  end

endmodule
